// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one iteration per clock, WIDTH iterations per operation.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic               annul,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               ready,
    output logic [2*WIDTH-1:0] result,
    output logic               div_zero,
    output logic [1:0]         o_dbg_state
);

    // Handshake: start is taken only in IDLE (annul wins); ready pulses for the one
    // DONE cycle, and result/div_zero then hold until the next ready pulse.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] LAST_ITER = WIDTH'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_load_res;

    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_opb;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_cnt;
    logic               r_bzero;
    logic               r_neg_lo;
    logic               r_neg_hi;
    logic [2*WIDTH-1:0] r_result;
    logic               r_div_zero;

    logic               w_signed;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH-1:0]   w_mul_hi;
    logic [WIDTH-1:0]   w_mul_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_ge;
    logic [WIDTH-1:0]   w_sub;
    logic [WIDTH-1:0]   w_div_hi;
    logic [WIDTH-1:0]   w_div_lo;
    logic [2*WIDTH-1:0] w_final;

    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_load_res  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !annul) begin
                    w_accept    = 1'b1;
                    w_state_nxt = op[1] ? S_DIV : S_MUL;
                end
            end
            S_MUL: begin
                if (annul) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == LAST_ITER) begin
                    w_load_res  = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DIV: begin
                if (annul) begin
                    w_state_nxt = S_IDLE;
                end else if (r_bzero || (r_cnt == LAST_ITER)) begin
                    w_load_res  = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_signed = ~op[0];

    // Multiply: r_lo holds the remaining multiplier bits, product shifts in from the top.
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
    assign w_mul_hi  = w_mul_sum[WIDTH:1];
    assign w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    assign w_prod    = {w_mul_hi, w_mul_lo};

    // Divide: r_hi is the partial remainder, r_lo shifts dividend out / quotient in.
    assign w_rem_sh = {r_hi, r_lo[WIDTH-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_opb});
    assign w_sub    = w_rem_sh[WIDTH-1:0] - r_opb;
    assign w_div_hi = w_ge ? w_sub : w_rem_sh[WIDTH-1:0];
    assign w_div_lo = {r_lo[WIDTH-2:0], w_ge};

    always_comb begin
        w_final = '0;
        if (r_state == S_MUL) begin
            w_final = r_neg_lo ? -w_prod : w_prod;
        end else if (r_bzero) begin
            w_final = {r_a, {WIDTH{1'b1}}};
        end else begin
            w_final = {(r_neg_hi ? -w_div_hi : w_div_hi), (r_neg_lo ? -w_div_lo : w_div_lo)};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi       <= '0;
            r_lo       <= '0;
            r_opb      <= '0;
            r_a        <= '0;
            r_cnt      <= '0;
            r_bzero    <= 1'b0;
            r_neg_lo   <= 1'b0;
            r_neg_hi   <= 1'b0;
            r_result   <= '0;
            r_div_zero <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hi     <= '0;
                r_lo     <= f_mag(a, w_signed);
                r_opb    <= f_mag(b, w_signed);
                r_a      <= a;
                r_cnt    <= '0;
                r_bzero  <= (b == '0);
                r_neg_lo <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                r_neg_hi <= w_signed & a[WIDTH-1];
            end else if ((r_state == S_MUL) && !annul) begin
                r_hi  <= w_mul_hi;
                r_lo  <= w_mul_lo;
                r_cnt <= r_cnt + WIDTH'(1);
            end else if ((r_state == S_DIV) && !annul) begin
                r_hi  <= w_div_hi;
                r_lo  <= w_div_lo;
                r_cnt <= r_cnt + WIDTH'(1);
            end
            if (w_load_res) begin
                r_result   <= w_final;
                r_div_zero <= (r_state == S_DIV) && r_bzero;
            end
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign ready       = (r_state == S_DONE);
    assign result      = r_result;
    assign div_zero    = r_div_zero;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32: vector table plus annul and reset sequences.
module tb_muldiv_unit;

    localparam int W = 32;

    logic           clk;
    logic           rst;
    logic           start;
    logic [1:0]     op;
    logic           annul;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           ready;
    logic [2*W-1:0] result;
    logic           div_zero;
    logic [1:0]     dbg_state;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]     op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] res;
        logic           dz;
        int             lat;
    } vec_t;

    vec_t vecs [12];

    muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .annul       (annul),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .ready       (ready),
        .result      (result),
        .div_zero    (div_zero),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; the next edge is the acceptance edge.
    task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 2'($urandom_range(0, 3));
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_ready(input logic [2*W-1:0] prev, output int lat,
                              output logic busy_ok, output logic hold_ok);
        lat     = 0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (ready) begin
                lat = k;
                break;
            end
            if (result !== prev) hold_ok = 1'b0;
        end
    endtask

    initial begin
        logic [2*W-1:0] prev;
        int             lat;
        logic           busy_ok;
        logic           hold_ok;
        logic           seen;

        vecs[0]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFF_FFFFFFF1, 1'b0, 33};
        vecs[1]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 33};
        vecs[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 64'h00000001_7FFFFFFC, 1'b0, 33};
        vecs[3]  = '{2'b11, 32'h12345678, 32'h00000000, 64'h12345678_FFFFFFFF, 1'b1, 2};
        vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 33};
        vecs[5]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, 33};
        vecs[6]  = '{2'b00, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0, 33};
        vecs[7]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, 33};
        vecs[8]  = '{2'b00, 32'h00000007, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFF9, 1'b0, 33};
        vecs[9]  = '{2'b10, 32'hFFFFFFFB, 32'h00000000, 64'hFFFFFFFB_FFFFFFFF, 1'b1, 2};
        vecs[10] = '{2'b11, 32'h00000064, 32'h00000007, 64'h00000002_0000000E, 1'b0, 33};
        vecs[11] = '{2'b11, 32'h00000005, 32'hFFFFFFFF, 64'h00000005_00000000, 1'b0, 33};

        rst   = 1'b0;
        start = 1'b0;
        annul = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        #3;
        chk("reset_busy",     64'(busy),      64'd0);
        chk("reset_ready",    64'(ready),     64'd0);
        chk("reset_result",   result,         64'd0);
        chk("reset_div_zero", 64'(div_zero),  64'd0);
        chk("reset_state",    64'(dbg_state), 64'd0);

        // Release and launch immediately: the first edge after release must accept.
        @(posedge clk);
        #1;
        rst  = 1'b1;
        prev = '0;
        for (int i = 0; i < 12; i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_ready(prev, lat, busy_ok, hold_ok);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            chk($sformatf("v%0d_result", i), result, vecs[i].res);
            chk($sformatf("v%0d_div_zero", i), 64'(div_zero), 64'(vecs[i].dz));
            chk($sformatf("v%0d_busy_held", i), 64'(busy_ok), 64'd1);
            chk($sformatf("v%0d_result_held", i), 64'(hold_ok), 64'd1);
            prev = vecs[i].res;
            @(negedge clk);
            chk($sformatf("v%0d_ready_pulse", i), 64'(ready), 64'd0);
            chk($sformatf("v%0d_idle_busy", i), 64'(busy), 64'd0);
            @(posedge clk);
            #1;
        end

        // MULTU annulled at T+10, then restarted at T+11.
        seen = 1'b0;
        launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (9) begin
            @(negedge clk);
            if (ready) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        annul = 1'b1;
        @(posedge clk);
        #1;
        annul = 1'b0;
        chk("annul_busy",   64'(busy),  64'd0);
        chk("annul_ready",  64'(ready), 64'd0);
        chk("annul_result", result,     prev);
        chk("annul_no_ready_seen", 64'(seen), 64'd0);
        launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_ready(prev, lat, busy_ok, hold_ok);
        chk("restart_latency", 64'(lat), 64'd33);
        chk("restart_result",  result,   64'hFFFFFFFE_00000001);
        prev = 64'hFFFFFFFE_00000001;
        @(posedge clk);
        #1;

        // annul and start together in IDLE: start is dropped.
        start = 1'b1;
        annul = 1'b1;
        op    = 2'b00;
        a     = 32'h3;
        b     = 32'h3;
        @(posedge clk);
        #1;
        start = 1'b0;
        annul = 1'b0;
        chk("annul_over_start_busy", 64'(busy), 64'd0);
        chk("annul_over_start_result", result, prev);

        // Reset asserted at T+5 of a DIV.
        @(posedge clk);
        #1;
        launch(2'b10, 32'h00001000, 32'h00000003);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        #1;
        chk("midrst_busy",     64'(busy),     64'd0);
        chk("midrst_ready",    64'(ready),    64'd0);
        chk("midrst_result",   result,        64'd0);
        chk("midrst_div_zero", 64'(div_zero), 64'd0);
        #20;
        @(posedge clk);
        #1;
        rst  = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready || busy) seen = 1'b1;
        end
        chk("post_reset_quiet", 64'(seen), 64'd0);
        @(posedge clk);
        #1;
        launch(2'b00, 32'h00000007, 32'hFFFFFFFF);
        wait_ready(64'd0, lat, busy_ok, hold_ok);
        chk("post_reset_latency", 64'(lat), 64'd33);
        chk("post_reset_result",  result,   64'hFFFFFFFF_FFFFFFF9);
        chk("post_reset_held",    64'(hold_ok), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand width in bits; legal values are even and from 8 to 64.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL provide port op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU; sampled with start.
REQ-006 SHALL provide port annul  input  1  abort of the operation in flight.
REQ-007 SHALL provide ports a, b  input  WIDTH each  operands (multiplicand/multiplier, dividend/divisor).
REQ-008 SHALL provide port busy  output  1  high in MUL, DIV and DONE.
REQ-009 SHALL provide port ready  output  1  one-cycle pulse, result valid.
REQ-010 SHALL provide port result  output  2*WIDTH  {hi, lo}: product {upper, lower}; division {remainder, quotient}.
REQ-011 SHALL provide port div_zero  output  1  high with ready when a division had b == 0.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-013 SHALL, in IDLE with start=1 and annul=0, latch a, b and op, and move to MUL (op[1]=0) or DIV (op[1]=1) on the next edge (acceptance cycle T).
REQ-014 SHALL operate on operand magnitudes for signed ops, with a WIDTH-bit counter, one iteration per cycle.
REQ-015 SHALL use radix-2 shift-add in MUL and restoring shift-subtract in DIV, WIDTH iterations, in cycles T+1..T+WIDTH.
REQ-016 SHALL enter DONE at T+WIDTH+1, assert ready for exactly that cycle, then return to IDLE unconditionally.
REQ-017 SHALL, for signed MULT, negate the 2*WIDTH product when the operand signs differ.
REQ-018 SHALL, for signed DIV, truncate the quotient toward zero, give the remainder the sign of the dividend, and return quotient = most-negative, remainder = 0 for most-negative / -1 (no trap).
REQ-019 SHALL, for DIV/DIVU with b == 0, skip the iterations, enter DONE at T+2, and return result = {a, all-ones} with div_zero=1.
REQ-020 SHALL apply the final sign correction before the DONE edge, so result is valid in the ready cycle.
REQ-021 SHALL hold result and div_zero from the ready cycle until the next ready; they SHALL NOT change during a computation.
REQ-022 SHALL ignore start in MUL, DIV and DONE; no queuing.
REQ-023 SHALL, on annul=1 in MUL or DIV, return to IDLE on the next edge, with no ready and result unchanged.
REQ-024 SHALL give annul priority over start when both are high in IDLE; the start is dropped.
REQ-025 SHALL ignore annul in DONE; the ready pulse still occurs.
REQ-026 SHALL ignore changes on a, b and op after acceptance.

Reset
REQ-027 SHALL, while rst=0, force state IDLE, busy=0, ready=0, div_zero=0, result=0, counter=0, regardless of clk.
REQ-028 SHALL, on reset in the middle of an operation, discard it with no ready after release.
REQ-029 SHALL accept a start in the first clk edge after rst deasserts.

Verification (WIDTH=32)
REQ-030 SHALL check: MULT a=FFFFFFFD (-3), b=00000005, start at T -> ready at T+33, result=FFFFFFFF_FFFFFFF1, busy high for T+1..T+33.
REQ-031 SHALL check: DIV a=FFFFFFF9 (-7), b=00000002 -> result=FFFFFFFF_FFFFFFFD; DIVU same operands -> result=00000001_7FFFFFFC.
REQ-032 SHALL check: DIVU a=12345678, b=0 -> ready at T+2, result=12345678_FFFFFFFF, div_zero=1.
REQ-033 SHALL check: DIV a=80000000, b=FFFFFFFF -> result=00000000_80000000, div_zero=0.
REQ-034 SHALL check: MULTU FFFFFFFF x FFFFFFFF, annul at T+10 -> busy=0 at T+11, no ready, result keeps its prior value; a new start at T+11 completes at T+44 with FFFFFFFE_00000001.
REQ-035 SHALL check: rst low at T+5 of a DIV -> all outputs 0 immediately; no ready for 40 cycles after release without a new start.
